// File: rtl/dp_fifo_pkg.sv
// Shared definitions for the dp_ram FIFO controller.
//   DEF_DATA_W / DEF_ADDR_W : default word and RAM address widths
//   BUF_DEPTH               : entries in the output buffer that hides RAM read latency
//   data_t / addr_t / cnt_t : word, RAM address and occupancy-count types at default widths
package dp_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned BUF_DEPTH  = 2;

    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_ADDR_W+1:0] cnt_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order output buffer with first-word-fall-through valid/ready output.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   wr_en, wr_data     : single write port (RAM read return)
//   m_valid, m_ready   : output handshake; a pop happens when both are high
//   m_data             : oldest entry
//   buf_cnt            : number of occupied entries (0..2)
module fifo_out_buf
    import dp_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        buf_cnt
);

    logic [DATA_W-1:0] ent0_q, ent0_d;  // head
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop;

    assign m_valid = rst & (cnt_q != 2'd0);
    assign m_data  = ent0_q;
    assign buf_cnt = cnt_q;
    assign pop     = m_valid & m_ready;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({wr_en, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = wr_data;
                else               ent1_d = wr_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word goes behind whatever remains.
                if (cnt_q == 2'(BUF_DEPTH)) begin
                    ent0_d = ent1_q;
                    ent1_d = wr_data;
                end else begin
                    ent0_d = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    // A return into a full buffer without a pop would lose a word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(wr_en && (cnt_q == 2'(BUF_DEPTH)) && !pop));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst)
        cnt_q <= 2'(BUF_DEPTH));

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller placed directly upstream of dp_ram. Converts a valid/ready write stream
// into RAM writes, issues RAM reads, and returns the read data as a first-word-fall-through
// valid/ready stream. A 2-entry output buffer hides the one-cycle RAM read latency.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   s_valid, s_ready, s_data       : write stream
//   m_valid, m_ready, m_data       : read stream (FWFT)
//   count                          : words held (RAM + in-flight read + output buffer)
//   ram_wr_en/ram_wr_addr/ram_w_data : dp_ram write port
//   ram_rd_en/ram_rd_addr/ram_r_data : dp_ram read port (data valid the cycle after rd_en)
module dp_ram_fifo_ctrl
    import dp_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W+1:0] count,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_w_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_r_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W+1:0] count_q, count_d;

    logic              push, issue, pop;
    logic [1:0]        buf_cnt;
    logic [2:0]        committed;

    // s_ready looks only at the registered RAM occupancy, so a same-cycle read never
    // frees a slot early and the write address can never collide with the read address.
    assign s_ready = rst & (ram_cnt_q != (ADDR_W+1)'(DEPTH));
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Words already headed for the output buffer, net of the current pop.
    assign committed = {1'b0, buf_cnt} + {2'b00, rd_pend_q};
    assign issue     = rst & (ram_cnt_q != '0) & (committed < (3'd2 + {2'b00, pop}));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_pend_d = issue;
        ram_cnt_d = ram_cnt_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, issue};
        count_d   = count_q + {{(ADDR_W+1){1'b0}}, push} - {{(ADDR_W+1){1'b0}}, pop};
        // Pointers wrap modulo DEPTH through natural ADDR_W-bit overflow.
        if (push)  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            count_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
            count_q   <= count_d;
        end
    end

    fifo_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rd_pend_q),
        .wr_data (ram_r_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .buf_cnt (buf_cnt)
    );

    assign count       = rst ? count_q : '0;
    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_w_data  = s_data;
    assign ram_rd_en   = issue;
    assign ram_rd_addr = rd_ptr_q;

    a_ram_cnt_range: assert property (@(posedge clk) disable iff (!rst)
        ram_cnt_q <= (ADDR_W+1)'(DEPTH));
    a_no_addr_clash: assert property (@(posedge clk) disable iff (!rst)
        (push && issue) |-> (wr_ptr_q != rd_ptr_q));
    a_count_sum: assert property (@(posedge clk) disable iff (!rst)
        count_q == (ADDR_W+2)'(ram_cnt_q) + (ADDR_W+2)'(rd_pend_q) + (ADDR_W+2)'(buf_cnt));

endmodule
